// File: rtl/axi4_sram_responder.sv
// AXI4 slave that terminates the bus into a word-addressed SRAM with a fixed response latency.
// Optional out-of-range DECERR reporting is enabled by defining AXI4_SRAM_RANGE_CHECK_EN.
module axi4_sram_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 3
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_arready,
  input  logic        in_arvalid,
  input  logic [3:0]  in_arid,
  input  logic [31:0] in_araddr,
  input  logic [7:0]  in_arlen,
  input  logic [2:0]  in_arsize,
  input  logic [1:0]  in_arburst,
  input  logic        in_rready,
  output logic        in_rvalid,
  output logic [3:0]  in_rid,
  output logic [31:0] in_rdata,
  output logic [1:0]  in_rresp,
  output logic        in_rlast,
  output logic        in_awready,
  input  logic        in_awvalid,
  input  logic [3:0]  in_awid,
  input  logic [31:0] in_awaddr,
  input  logic [7:0]  in_awlen,
  input  logic [2:0]  in_awsize,
  input  logic [1:0]  in_awburst,
  output logic        in_wready,
  input  logic        in_wvalid,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_wstrb,
  input  logic        in_wlast,
  input  logic        in_bready,
  output logic        in_bvalid,
  output logic [3:0]  in_bid,
  output logic [1:0]  in_bresp
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DATA,
    WR_DATA,
    WR_WAIT,
    WR_RESP
  } state_t;

  state_t state_q, state_d;

  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [7:0]  beat_q;
  logic [7:0]  cnt_q;
  logic        wr_err_q;
  logic        wr_dec_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [1:0]  bresp_q;

  logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

  logic                  last_beat;
  logic [1:0]            eff_size;
  logic [31:0]           next_addr;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [DEPTH_LOG2-1:0] nxt_idx;
  logic                  cur_oob;
  logic                  nxt_oob;
  logic                  ar_hs, aw_hs, r_hs, w_hs;

  assign last_beat = (beat_q == len_q);
  assign cur_idx   = addr_q[DEPTH_LOG2+1:2];
  assign nxt_idx   = next_addr[DEPTH_LOG2+1:2];

  always_comb begin
    eff_size  = (size_q > 3'd2) ? 2'd2 : size_q[1:0];
    next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << eff_size);
  end

`ifdef AXI4_SRAM_RANGE_CHECK_EN
  assign cur_oob = |addr_q[31:DEPTH_LOG2+2];
  assign nxt_oob = |next_addr[31:DEPTH_LOG2+2];
`else
  assign cur_oob = 1'b0;
  assign nxt_oob = 1'b0;
`endif

  assign ar_hs = in_arready & in_arvalid;
  assign aw_hs = in_awready & in_awvalid;
  assign r_hs  = in_rvalid & in_rready;
  assign w_hs  = in_wready & in_wvalid;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // IDLE readies are also masked by reset so nothing is accepted while reset is held.
  always_comb begin
    state_d    = state_q;
    in_arready = 1'b0;
    in_awready = 1'b0;
    in_rvalid  = 1'b0;
    in_wready  = 1'b0;
    in_bvalid  = 1'b0;
    in_rlast   = 1'b0;
    case (state_q)
      IDLE: begin
        in_arready = reset;
        in_awready = reset & ~in_arvalid;
        if (in_arvalid)      state_d = RD_WAIT;
        else if (in_awvalid) state_d = WR_DATA;
      end
      RD_WAIT: if (cnt_q == 8'd0) state_d = RD_DATA;
      RD_DATA: begin
        in_rvalid = 1'b1;
        in_rlast  = last_beat;
        if (in_rready && last_beat) state_d = IDLE;
      end
      WR_DATA: begin
        in_wready = 1'b1;
        if (in_wvalid && last_beat) state_d = WR_WAIT;
      end
      WR_WAIT: if (cnt_q == 8'd0) state_d = WR_RESP;
      WR_RESP: begin
        in_bvalid = 1'b1;
        if (in_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
      wr_dec_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      bresp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_hs) begin
            id_q    <= in_arid;
            addr_q  <= in_araddr;
            len_q   <= in_arlen;
            size_q  <= in_arsize;
            burst_q <= in_arburst;
            beat_q  <= '0;
            cnt_q   <= 8'(LATENCY);
          end else if (aw_hs) begin
            id_q     <= in_awid;
            addr_q   <= in_awaddr;
            len_q    <= in_awlen;
            size_q   <= in_awsize;
            burst_q  <= in_awburst;
            beat_q   <= '0;
            wr_err_q <= 1'b0;
            wr_dec_q <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (cnt_q == 8'd0) begin
            rdata_q <= cur_oob ? '0 : mem[cur_idx];
            rresp_q <= cur_oob ? 2'b11 : 2'b00;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            beat_q <= beat_q + 8'd1;
            addr_q <= next_addr;
            if (!last_beat) begin
              rdata_q <= nxt_oob ? '0 : mem[nxt_idx];
              rresp_q <= nxt_oob ? 2'b11 : 2'b00;
            end
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            beat_q <= beat_q + 8'd1;
            addr_q <= next_addr;
            if (in_wlast != last_beat) wr_err_q <= 1'b1;
            if (cur_oob)               wr_dec_q <= 1'b1;
            if (last_beat)             cnt_q    <= 8'(LATENCY);
          end
        end
        WR_WAIT: begin
          if (cnt_q == 8'd0) bresp_q <= wr_dec_q ? 2'b11 : (wr_err_q ? 2'b10 : 2'b00);
          else               cnt_q   <= cnt_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // SRAM contents survive reset; only the write strobe is qualified by it.
  always_ff @(posedge clock) begin
    if (reset && w_hs && !cur_oob) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (in_wstrb[i]) mem[cur_idx][8*i +: 8] <= in_wdata[8*i +: 8];
      end
    end
  end

  assign in_rid   = id_q;
  assign in_rdata = rdata_q;
  assign in_rresp = rresp_q;
  assign in_bid   = id_q;
  assign in_bresp = bresp_q;

endmodule

// File: tb/tb_axi4_sram_responder.sv
// Directed self-checking bench for axi4_sram_responder: single-beat vector table plus burst,
// stall, arbitration and reset sequences. Honours AXI4_SRAM_RANGE_CHECK_EN for expectations.
module tb_axi4_sram_responder;

  localparam int unsigned LAT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_arready, in_arvalid;
  logic [3:0]  in_arid;
  logic [31:0] in_araddr;
  logic [7:0]  in_arlen;
  logic [2:0]  in_arsize;
  logic [1:0]  in_arburst;
  logic        in_rready, in_rvalid;
  logic [3:0]  in_rid;
  logic [31:0] in_rdata;
  logic [1:0]  in_rresp;
  logic        in_rlast;
  logic        in_awready, in_awvalid;
  logic [3:0]  in_awid;
  logic [31:0] in_awaddr;
  logic [7:0]  in_awlen;
  logic [2:0]  in_awsize;
  logic [1:0]  in_awburst;
  logic        in_wready, in_wvalid;
  logic [31:0] in_wdata;
  logic [3:0]  in_wstrb;
  logic        in_wlast;
  logic        in_bready, in_bvalid;
  logic [3:0]  in_bid;
  logic [1:0]  in_bresp;

  axi4_sram_responder #(.DEPTH_LOG2(12), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .in_arready(in_arready), .in_arvalid(in_arvalid), .in_arid(in_arid), .in_araddr(in_araddr),
    .in_arlen(in_arlen), .in_arsize(in_arsize), .in_arburst(in_arburst),
    .in_rready(in_rready), .in_rvalid(in_rvalid), .in_rid(in_rid), .in_rdata(in_rdata),
    .in_rresp(in_rresp), .in_rlast(in_rlast),
    .in_awready(in_awready), .in_awvalid(in_awvalid), .in_awid(in_awid), .in_awaddr(in_awaddr),
    .in_awlen(in_awlen), .in_awsize(in_awsize), .in_awburst(in_awburst),
    .in_wready(in_wready), .in_wvalid(in_wvalid), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
    .in_wlast(in_wlast),
    .in_bready(in_bready), .in_bvalid(in_bvalid), .in_bid(in_bid), .in_bresp(in_bresp)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_d [256];
  logic [31:0] wdat  [256];

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit wr, input logic [3:0] id, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         input logic [1:0] resp, input string name);
    vec_t v;
    v.wr = wr; v.id = id; v.addr = addr; v.data = data;
    v.strb = strb; v.resp = resp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input string name);
    int n = 0;
    in_arid = id; in_araddr = addr; in_arlen = len; in_arsize = size; in_arburst = burst;
    in_arvalid = 1'b1;
    while (!in_arready && n < 1000) begin tick(); n++; end
    chk({name, "_arready"}, 32'(in_arready), 32'd1);
    tick();
    in_arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input string name);
    int n = 0;
    in_awid = id; in_awaddr = addr; in_awlen = len; in_awsize = size; in_awburst = burst;
    in_awvalid = 1'b1;
    while (!in_awready && n < 1000) begin tick(); n++; end
    chk({name, "_awready"}, 32'(in_awready), 32'd1);
    tick();
    in_awvalid = 1'b0;
  endtask

  // Called right after the AR handshake edge; checks latency, beats, stalls and rvalid drop.
  task automatic rd_data(input logic [3:0] id, input int len, input logic [1:0] resp,
                         input logic [3:0] rpat, input string name);
    int n = 0;
    int beat = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [31:0] held_d;
    logic held_l;
    while (!in_rvalid && n < 1000) begin tick(); n++; end
    chk({name, "_latency"}, n, LAT + 1);
    while (beat <= len && cyc < 2000) begin
      in_rready = rpat[cyc % 4];
      if (stalled) begin
        chk($sformatf("%s_hold_valid%0d", name, beat), 32'(in_rvalid), 32'd1);
        chk($sformatf("%s_hold_data%0d", name, beat), in_rdata, held_d);
        chk($sformatf("%s_hold_last%0d", name, beat), 32'(in_rlast), 32'(held_l));
        stalled = 1'b0;
      end
      if (in_rvalid && in_rready) begin
        chk($sformatf("%s_rdata%0d", name, beat), in_rdata, exp_d[beat]);
        chk($sformatf("%s_rlast%0d", name, beat), 32'(in_rlast), 32'(beat == len));
        chk($sformatf("%s_rid%0d", name, beat), 32'(in_rid), 32'(id));
        chk($sformatf("%s_rresp%0d", name, beat), 32'(in_rresp), 32'(resp));
        beat++;
      end else if (in_rvalid) begin
        held_d = in_rdata;
        held_l = in_rlast;
        stalled = 1'b1;
      end
      tick();
      cyc++;
    end
    in_rready = 1'b0;
    chk({name, "_beats"}, beat, len + 1);
    chk({name, "_rvalid_drop"}, 32'(in_rvalid), 32'd0);
  endtask

  // Called right after the AW handshake edge; wlast is driven only on beat wlast_beat.
  task automatic wr_data(input logic [3:0] id, input int len, input int wlast_beat,
                         input logic [3:0] strb, input logic [1:0] bresp, input string name);
    int n;
    for (int b = 0; b <= len; b++) begin
      in_wvalid = 1'b1;
      in_wdata  = wdat[b];
      in_wstrb  = strb;
      in_wlast  = (b == wlast_beat);
      n = 0;
      while (!in_wready && n < 1000) begin tick(); n++; end
      chk($sformatf("%s_wready%0d", name, b), 32'(in_wready), 32'd1);
      tick();
    end
    in_wvalid = 1'b0;
    in_wlast  = 1'b0;
    n = 0;
    while (!in_bvalid && n < 1000) begin tick(); n++; end
    chk({name, "_b_latency"}, n, LAT + 1);
    chk({name, "_bid"}, 32'(in_bid), 32'(id));
    chk({name, "_bresp"}, 32'(in_bresp), 32'(bresp));
    in_bready = 1'b1;
    tick();
    in_bready = 1'b0;
    chk({name, "_bvalid_drop"}, 32'(in_bvalid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    in_arvalid = 0; in_arid = 0; in_araddr = 0; in_arlen = 0; in_arsize = 0; in_arburst = 0;
    in_awvalid = 0; in_awid = 0; in_awaddr = 0; in_awlen = 0; in_awsize = 0; in_awburst = 0;
    in_rready = 0; in_wvalid = 0; in_wdata = 0; in_wstrb = 0; in_wlast = 0; in_bready = 0;

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_arready", 32'(in_arready), 32'd0);
    chk("rst_awready", 32'(in_awready), 32'd0);
    chk("rst_rvalid",  32'(in_rvalid),  32'd0);
    chk("rst_wready",  32'(in_wready),  32'd0);
    chk("rst_bvalid",  32'(in_bvalid),  32'd0);
    chk("rst_rdata",   in_rdata,        32'd0);
    chk("rst_rid",     32'(in_rid),     32'd0);
    chk("rst_rresp",   32'(in_rresp),   32'd0);
    chk("rst_rlast",   32'(in_rlast),   32'd0);
    chk("rst_bid",     32'(in_bid),     32'd0);
    chk("rst_bresp",   32'(in_bresp),   32'd0);
    reset = 1'b1;
    tick();

    // Single-beat vector table
    add_vec(1, 4'd1, 32'h40,  32'hDEADBEEF, 4'hF,    2'b00, "wr_preload");
    add_vec(0, 4'd5, 32'h40,  32'hDEADBEEF, 4'h0,    2'b00, "rd_t1");
    add_vec(1, 4'd3, 32'h200, 32'h11223344, 4'hF,    2'b00, "wr_base");
    add_vec(1, 4'd3, 32'h200, 32'hAABBCCDD, 4'b0101, 2'b00, "wr_strb0101");
    add_vec(0, 4'd4, 32'h200, 32'h11BB33DD, 4'h0,    2'b00, "rd_strb0101");
    add_vec(1, 4'd6, 32'h200, 32'h55667788, 4'b1000, 2'b00, "wr_strb1000");
    add_vec(0, 4'd7, 32'h200, 32'h55BB33DD, 4'h0,    2'b00, "rd_strb1000");
`ifdef AXI4_SRAM_RANGE_CHECK_EN
    add_vec(1, 4'd9,  32'h4040, 32'hCAFEF00D, 4'hF, 2'b11, "wr_oob");
    add_vec(0, 4'd10, 32'h40,   32'hDEADBEEF, 4'h0, 2'b00, "rd_not_aliased");
    add_vec(0, 4'd11, 32'h4000, 32'h00000000, 4'h0, 2'b11, "rd_oob");
`else
    add_vec(1, 4'd9,  32'h4040, 32'hCAFEF00D, 4'hF, 2'b00, "wr_alias");
    add_vec(0, 4'd10, 32'h40,   32'hCAFEF00D, 4'h0, 2'b00, "rd_alias");
`endif
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        aw_send(vecs[i].id, vecs[i].addr, 8'd0, 3'd2, 2'b01, vecs[i].name);
        wdat[0] = vecs[i].data;
        wr_data(vecs[i].id, 0, 0, vecs[i].strb, vecs[i].resp, vecs[i].name);
      end else begin
        ar_send(vecs[i].id, vecs[i].addr, 8'd0, 3'd2, 2'b01, vecs[i].name);
        exp_d[0] = vecs[i].data;
        rd_data(vecs[i].id, 0, vecs[i].resp, 4'b1111, vecs[i].name);
      end
    end

    // 4-beat INCR write and read-back
    wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
    aw_send(4'd2, 32'h100, 8'd3, 3'd2, 2'b01, "burst_wr");
    wr_data(4'd2, 3, 3, 4'hF, 2'b00, "burst_wr");
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    ar_send(4'd2, 32'h100, 8'd3, 3'd2, 2'b01, "burst_rd");
    rd_data(4'd2, 3, 2'b00, 4'b1111, "burst_rd");

    // rready 1,0,0,1 backpressure
    ar_send(4'd8, 32'h100, 8'd3, 3'd2, 2'b01, "stall_rd");
    rd_data(4'd8, 3, 2'b00, 4'b1001, "stall_rd");

    // Narrow (byte) INCR read stays within one word; oversize clamps to 4-byte steps
    exp_d[0] = 32'h11; exp_d[1] = 32'h11; exp_d[2] = 32'h11; exp_d[3] = 32'h11;
    ar_send(4'd3, 32'h100, 8'd3, 3'd0, 2'b01, "narrow_rd");
    rd_data(4'd3, 3, 2'b00, 4'b1111, "narrow_rd");
    exp_d[0] = 32'h11; exp_d[1] = 32'h22;
    ar_send(4'd3, 32'h100, 8'd1, 3'd3, 2'b11, "size3_rd");
    rd_data(4'd3, 1, 2'b00, 4'b1111, "size3_rd");

    // FIXED burst: both beats hit the same word
    wdat[0] = 32'hA5A5A5A5; wdat[1] = 32'h5A5A5A5A;
    aw_send(4'd4, 32'h180, 8'd1, 3'd2, 2'b00, "fixed_wr");
    wr_data(4'd4, 1, 1, 4'hF, 2'b00, "fixed_wr");
    exp_d[0] = 32'h5A5A5A5A; exp_d[1] = 32'h5A5A5A5A;
    ar_send(4'd4, 32'h180, 8'd1, 3'd2, 2'b00, "fixed_rd");
    rd_data(4'd4, 1, 2'b00, 4'b1111, "fixed_rd");

    // Early wlast: burst still runs 4 beats, SLVERR reported, data written
    wdat[0] = 32'h1; wdat[1] = 32'h2; wdat[2] = 32'h3; wdat[3] = 32'h4;
    aw_send(4'd9, 32'h300, 8'd3, 3'd2, 2'b01, "wlast_err");
    wr_data(4'd9, 3, 1, 4'hF, 2'b10, "wlast_err");
    exp_d[0] = 32'h1; exp_d[1] = 32'h2; exp_d[2] = 32'h3; exp_d[3] = 32'h4;
    ar_send(4'd9, 32'h300, 8'd3, 3'd2, 2'b01, "wlast_err_rd");
    rd_data(4'd9, 3, 2'b00, 4'b1111, "wlast_err_rd");

    // AR and AW together: read wins, AW taken in the first IDLE cycle afterwards
    in_arid = 4'd1; in_araddr = 32'h100; in_arlen = 8'd0; in_arsize = 3'd2; in_arburst = 2'b01;
    in_awid = 4'd2; in_awaddr = 32'h304; in_awlen = 8'd0; in_awsize = 3'd2; in_awburst = 2'b01;
    in_arvalid = 1'b1;
    in_awvalid = 1'b1;
    #1;
    chk("arb_arready", 32'(in_arready), 32'd1);
    chk("arb_awready", 32'(in_awready), 32'd0);
    tick();
    in_arvalid = 1'b0;
    chk("arb_awready_busy", 32'(in_awready), 32'd0);
    exp_d[0] = 32'h11;
    rd_data(4'd1, 0, 2'b00, 4'b1111, "arb_rd");
    chk("arb_awready_idle", 32'(in_awready), 32'd1);
    tick();
    in_awvalid = 1'b0;
    wdat[0] = 32'hBEEF0001;
    wr_data(4'd2, 0, 0, 4'hF, 2'b00, "arb_wr");

    // Reset during beat 2 of a 4-beat read
    ar_send(4'd3, 32'h100, 8'd3, 3'd2, 2'b01, "rst_rd");
    seen = 0;
    while (!in_rvalid && seen < 1000) begin tick(); seen++; end
    in_rready = 1'b1;
    tick();
    tick();
    chk("rst_rd_beat2", in_rdata, 32'h33);
    reset = 1'b0;
    in_rready = 1'b0;
    tick();
    chk("rst_mid_rvalid",  32'(in_rvalid),  32'd0);
    chk("rst_mid_arready", 32'(in_arready), 32'd0);
    chk("rst_mid_rdata",   in_rdata,        32'd0);
    chk("rst_mid_rid",     32'(in_rid),     32'd0);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < int'(LAT) + 4; i++) begin
      tick();
      if (in_rvalid) seen++;
    end
    chk("rst_no_more_r", seen, 0);
    chk("rst_idle_arready", 32'(in_arready), 32'd1);
    exp_d[0] = 32'h11;
    ar_send(4'd6, 32'h100, 8'd0, 3'd2, 2'b01, "post_rst_rd");
    rd_data(4'd6, 0, 2'b00, 4'b1111, "post_rst_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
